// File: rtl/elastic_pipe_reg_pkg.sv
// Shared definitions for the elastic pipeline register.
//   PIPE_DEFAULT_WIDTH : default payload width of a slot.
//   clog2()            : ceiling log2, used to size the occupancy count.
package elastic_pipe_reg_pkg;

    localparam int unsigned PIPE_DEFAULT_WIDTH = 32;

    // Smallest r such that 2**r >= n.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if ((64'd1 << r) < 64'(n)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One register slot of the elastic pipeline: a valid bit plus a data word.
// Ports:
//   clk, rst           : clock, synchronous active-high reset (clears valid and data)
//   load               : capture valid_in this cycle
//   valid_in, data_in  : incoming valid/payload
//   valid_q, data_q    : registered valid/payload
// Data is written only when the incoming word is valid, so a bubble passing
// through (including a flush, which loads valid_in=0) leaves stale data alone.
module pipe_slot
    import elastic_pipe_reg_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= valid_in;
            if (valid_in) begin
                data_q <= data_in;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: DEPTH slots of WIDTH bits with valid/ready on
// both ends, bubble collapsing, freeze (hazard stall), flush (squash) and a
// registered occupancy count.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   freeze                         : hold all state, block input and output
//   flush                          : invalidate all slots on the next edge
//   in_valid, in_ready, in_data    : upstream handshake
//   out_valid, out_ready, out_data : downstream handshake (registered outputs)
//   occupancy                      : number of valid slots (registered)
module elastic_pipe_reg
    import elastic_pipe_reg_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_DEFAULT_WIDTH,
    parameter int unsigned DEPTH = 1,
    parameter int unsigned CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    occupancy
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   r;
    logic [DEPTH-1:0] load;
    logic             in_fire;
    logic             out_fire;
    logic [CW-1:0]    occ_q, occ_d;

    // Ready ripples from the output back to slot 0: a slot can take a word if
    // it is empty or its own word is moving on this cycle.
    always_comb begin
        r        = '0;
        r[DEPTH] = out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            r[i] = !v[i] || r[i+1];
        end
    end

    // A flush loads a bubble into every slot, clearing valids but keeping data.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            load[i] = flush || (r[i] && !freeze);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic             vin;
        logic [WIDTH-1:0] din;

        if (i == 0) begin : g_head
            assign vin = in_valid;
            assign din = in_data;
        end else begin : g_body
            assign vin = v[i-1];
            assign din = d[i-1];
        end

        pipe_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (load[i]),
            .valid_in(vin && !flush),
            .data_in (din),
            .valid_q (v[i]),
            .data_q  (d[i])
        );
    end

    assign in_ready  = r[0] && !freeze && !flush && !rst;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready && !freeze && !flush;

    always_comb begin
        occ_d = occ_q + CW'(in_fire) - CW'(out_fire);
        if (flush) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
module tb_elastic_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic        ir3, ov3, ir1, ov1;
    logic [31:0] od3;
    logic [7:0]  od1;
    logic [1:0]  occ3;
    logic [0:0]  occ1;

    logic        obs_in_ready, obs_out_valid;
    logic [31:0] obs_out_data, obs_occ;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: words ordered oldest first, each with its slot position.
    int          mdepth = 3;
    logic [31:0] mmask  = 32'hFFFF_FFFF;
    int          mpos[$];
    logic [31:0] mdat[$];
    logic [31:0] mlast = '0;

    logic [31:0] seen[$];
    int          peak;

    always #5 clk = ~clk;

    elastic_pipe_reg #(.WIDTH(32), .DEPTH(3)) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .freeze   (freeze),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (ir3),
        .in_data  (in_data),
        .out_valid(ov3),
        .out_ready(out_ready),
        .out_data (od3),
        .occupancy(occ3)
    );

    elastic_pipe_reg #(.WIDTH(8), .DEPTH(1)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .freeze   (freeze),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (ir1),
        .in_data  (in_data[7:0]),
        .out_valid(ov1),
        .out_ready(out_ready),
        .out_data (od1),
        .occupancy(occ1)
    );

    always_comb begin
        if (mdepth == 1) begin
            obs_in_ready  = ir1;
            obs_out_valid = ov1;
            obs_out_data  = {24'd0, od1};
            obs_occ       = {31'd0, occ1};
        end else begin
            obs_in_ready  = ir3;
            obs_out_valid = ov3;
            obs_out_data  = od3;
            obs_occ       = {30'd0, occ3};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check against the model, then advance both.
    task automatic cycle(input logic r, input logic f, input logic fl, input logic iv,
                         input logic [31:0] id, input logic ordy);
        logic        exp_ir, exp_ov;
        int          pred, np;
        int          npos[$];
        logic [31:0] ndat[$];
        logic [31:0] idm;
        idm = id & mmask;
        rst = r; freeze = f; flush = fl; in_valid = iv; in_data = idm; out_ready = ordy;
        #1;
        exp_ir = !r && !f && !fl && (mpos.size() < mdepth || ordy);
        exp_ov = mpos.size() > 0 && mpos[0] == mdepth - 1;
        check_eq("in_ready", {31'd0, obs_in_ready}, {31'd0, exp_ir});
        check_eq("out_valid", {31'd0, obs_out_valid}, {31'd0, exp_ov});
        check_eq("out_data", obs_out_data, mlast);
        check_eq("occupancy", obs_occ, mpos.size());
        if (int'(obs_occ) > peak) peak = int'(obs_occ);
        if (exp_ov && ordy && !r && !f && !fl) seen.push_back(obs_out_data);

        if (r) begin
            mpos.delete(); mdat.delete(); mlast = '0;
        end else if (fl) begin
            mpos.delete(); mdat.delete();
        end else if (!f) begin
            // Each word advances one slot unless blocked by the (moved) word ahead;
            // a word reaching position mdepth has left the pipe.
            pred = ordy ? mdepth + 1 : mdepth;
            foreach (mpos[k]) begin
                np = (mpos[k] + 1 < pred - 1) ? mpos[k] + 1 : pred - 1;
                if (np < mdepth) begin
                    npos.push_back(np);
                    ndat.push_back(mdat[k]);
                    if (np == mdepth - 1 && mpos[k] != mdepth - 1) mlast = mdat[k];
                end
                pred = np;
            end
            if (iv && exp_ir) begin
                npos.push_back(0);
                ndat.push_back(idm);
                if (mdepth == 1) mlast = idm;
            end
            mpos = npos;
            mdat = ndat;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; freeze = 0; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
        @(posedge clk);
        #1;
        mpos.delete(); mdat.delete(); mlast = '0;
        cycle(1, 0, 0, 1, 32'h5A5A_5A5A, 1);
        cycle(1, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic random_run(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                  ($urandom_range(15) == 0), ($urandom_range(9) < 7), $urandom,
                  ($urandom_range(9) < 6));
        end
    endtask

    initial begin
        logic [31:0] snap_d;
        logic        snap_v;
        logic [31:0] snap_o;
        int          hits;

        // Reset (DEPTH=3, WIDTH=32)
        mdepth = 3; mmask = 32'hFFFF_FFFF;
        do_reset();
        rst = 0; in_valid = 0; out_ready = 1;
        #1;
        check_eq("rst_release_in_ready", {31'd0, obs_in_ready}, 32'd1);

        // Streaming
        peak = 0; seen.delete();
        cycle(0, 0, 0, 1, 32'h11, 1);
        cycle(0, 0, 0, 1, 32'h22, 1);
        cycle(0, 0, 0, 1, 32'h33, 1);
        check_eq("stream_c3", obs_out_data, 32'h11);
        cycle(0, 0, 0, 0, 32'h0, 1);
        check_eq("stream_c4", obs_out_data, 32'h22);
        cycle(0, 0, 0, 0, 32'h0, 1);
        check_eq("stream_c5", obs_out_data, 32'h33);
        cycle(0, 0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 0, 32'h0, 1);
        check_eq("stream_peak", peak, 32'd3);

        // Back-pressure and bubble collapse
        seen.delete();
        cycle(0, 0, 0, 1, 32'hA, 0);
        cycle(0, 0, 0, 0, 32'h0, 0);
        cycle(0, 0, 0, 1, 32'hB, 0);
        cycle(0, 0, 0, 1, 32'hC, 0);
        rst = 0; in_valid = 1; in_data = 32'hD; out_ready = 0;
        #1;
        check_eq("bp_full_in_ready", {31'd0, obs_in_ready}, 32'd0);
        check_eq("bp_occ", obs_occ, 32'd3);
        check_eq("bp_head", obs_out_data, 32'hA);
        cycle(0, 0, 0, 1, 32'hD, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 32'h0, 1);
        check_eq("drain_count", seen.size(), 32'd3);
        check_eq("drain_0", (seen.size() > 0) ? seen[0] : 32'hX, 32'hA);
        check_eq("drain_1", (seen.size() > 1) ? seen[1] : 32'hX, 32'hB);
        check_eq("drain_2", (seen.size() > 2) ? seen[2] : 32'hX, 32'hC);

        // Freeze with two words held
        cycle(0, 0, 0, 1, 32'h51, 0);
        cycle(0, 0, 0, 1, 32'h52, 0);
        cycle(0, 0, 0, 0, 32'h0, 0);
        cycle(0, 0, 0, 0, 32'h0, 0);
        seen.delete();
        snap_d = obs_out_data; snap_v = obs_out_valid; snap_o = obs_occ;
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, 0, 1, 32'h99, 1);
            check_eq("frz_data", obs_out_data, snap_d);
            check_eq("frz_valid", {31'd0, obs_out_valid}, {31'd0, snap_v});
            check_eq("frz_occ", obs_occ, snap_o);
        end
        check_eq("frz_no_xfer", seen.size(), 32'd0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 32'h0, 1);
        check_eq("frz_resume_cnt", seen.size(), 32'd2);
        check_eq("frz_resume_0", (seen.size() > 0) ? seen[0] : 32'hX, 32'h51);
        check_eq("frz_resume_1", (seen.size() > 1) ? seen[1] : 32'hX, 32'h52);

        // Flush with freeze and in_valid
        cycle(0, 0, 0, 1, 32'h61, 0);
        cycle(0, 0, 0, 1, 32'h62, 0);
        cycle(0, 0, 0, 1, 32'h63, 0);
        check_eq("fl_pre_occ", obs_occ, 32'd3);
        seen.delete();
        cycle(0, 1, 1, 1, 32'hDEAD, 1);
        check_eq("fl_out_valid", {31'd0, obs_out_valid}, 32'd0);
        check_eq("fl_occ", obs_occ, 32'd0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 32'h0, 1);
        hits = 0;
        foreach (seen[k]) if (seen[k] == 32'hDEAD) hits++;
        check_eq("fl_dead_never", hits, 32'd0);
        check_eq("fl_nothing_out", seen.size(), 32'd0);

        random_run(400);

        // Edge parameters: DEPTH=1, WIDTH=8
        mdepth = 1; mmask = 32'h0000_00FF;
        do_reset();
        seen.delete();
        cycle(0, 0, 0, 1, 32'h80, 1);
        for (int k = 1; k <= 10; k++) begin
            rst = 0; freeze = 0; flush = 0; in_valid = 1; out_ready = 1;
            in_data = 32'h80 + k;
            #1;
            check_eq("d1_in_ready", {31'd0, obs_in_ready}, 32'd1);
            check_eq("d1_occ", obs_occ, 32'd1);
            cycle(0, 0, 0, 1, 32'h80 + k, 1);
        end
        check_eq("d1_rate", seen.size(), 32'd10);
        for (int k = 0; k < seen.size(); k++) check_eq("d1_order", seen[k], 32'h80 + k);

        random_run(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
